// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN convolution layer control path.
// Optional feature macro: CONV_PAD_EN selects zero-padded "same" convolution.
package bnn_pkg;

   localparam int IMG_DIM = 28;
   localparam int K_DIM   = 3;
   localparam int N_FILT  = 8;

   // Output positions per image side: every pixel is a window centre when
   // padded, otherwise only positions where the kernel fits inside the image.
`ifdef CONV_PAD_EN
   localparam int OUT_DIM = IMG_DIM;
`else
   localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   typedef logic [4:0] coord_t;
   typedef logic [2:0] filt_t;

endpackage

// File: rtl/conv_win_cnt.sv
// Nested filter/row/col window counter. Advances one window per 'adv',
// filter outermost and column innermost; 'last' flags the final window.
module conv_win_cnt
   import bnn_pkg::*;
#(
   parameter coord_t ROW_MAX  = coord_t'(OUT_DIM - 1),
   parameter coord_t COL_MAX  = coord_t'(OUT_DIM - 1),
   parameter filt_t  FILT_MAX = filt_t'(N_FILT - 1)
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   clr,
   input  logic   adv,
   output coord_t row,
   output coord_t col,
   output filt_t  filt,
   output logic   last
);

   coord_t row_d, col_d;
   filt_t  filt_d;
   logic   last_d;

   // Next coordinates: clear wins over advance; each digit wraps only on an
   // explicit compare with its maximum so no counter ever overshoots.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      row_d  = row;
      col_d  = col;
      filt_d = filt;
      if (clr) begin
         row_d  = '0;
         col_d  = '0;
         filt_d = '0;
      end else if (adv) begin
         if (col == COL_MAX) begin
            col_d = '0;
            if (row == ROW_MAX) begin
               row_d = '0;
               if (filt == FILT_MAX) filt_d = '0;
               else                  filt_d = filt + 1'b1;
            end else begin
               row_d = row + 1'b1;
            end
         end else begin
            col_d = col + 1'b1;
         end
      end
      last_d = (filt_d == FILT_MAX) && (row_d == ROW_MAX) && (col_d == COL_MAX);
   end

   // Coordinate and last-flag registers; 'last' is registered with the
   // coordinates so it holds stable alongside them during stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset_n) begin
         row  <= '0;
         col  <= '0;
         filt <= '0;
         last <= 1'b0;
      end else begin
         row  <= row_d;
         col  <= col_d;
         filt <= filt_d;
         last <= last_d;
      end
   end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution layer sequencer: arms the loader, then issues every window
// coordinate for every filter under valid/ready, then pulses done.
// Optional feature macro: CONV_PAD_EN (zero-padded "same" convolution).
module conv_sequencer #(
   parameter int IMG_DIM = bnn_pkg::IMG_DIM,
   parameter int K_DIM   = bnn_pkg::K_DIM,
   parameter int N_FILT  = bnn_pkg::N_FILT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       abort,
   input  logic       load_done,
   input  logic       win_ready,
   output logic       en_wr,
   output logic       win_valid,
   output logic [4:0] win_row,
   output logic [4:0] win_col,
   output logic [2:0] win_filt,
   output logic       win_last,
   output logic       busy,
   output logic       done
);

   import bnn_pkg::*;

   // Highest window coordinate: top-left corner when unpadded, centre when padded.
`ifdef CONV_PAD_EN
   localparam int SPAN = IMG_DIM;
`else
   localparam int SPAN = IMG_DIM - K_DIM + 1;
`endif

   localparam coord_t ROW_MAX  = coord_t'(SPAN - 1);
   localparam coord_t COL_MAX  = coord_t'(SPAN - 1);
   localparam filt_t  FILT_MAX = filt_t'(N_FILT - 1);

   seq_state_t state_q, state_d;
   logic       handshake;
   logic       en_wr_d, win_valid_d, busy_d, done_d;

   assign handshake = win_valid && win_ready;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; abort overrides every transition including start.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (start)                 state_d = LOAD;
            LOAD: if (load_done)             state_d = CONV;
            CONV: if (handshake && win_last) state_d = DONE;
            DONE:                            state_d = IDLE;
            default:                         state_d = IDLE;
         endcase
      end
   end

   // Output decode from the next state so the registered outputs line up
   // with the state they describe.
   always_comb begin
      en_wr_d     = (state_d == LOAD);
      win_valid_d = (state_d == CONV);
      busy_d      = (state_d == LOAD) || (state_d == CONV);
      done_d      = (state_d == DONE);
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_wr     <= 1'b0;
         win_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         en_wr     <= en_wr_d;
         win_valid <= win_valid_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Counters clear on abort and while in DONE; they advance on each
   // accepted window, which also wraps them to zero after the final beat.
   conv_win_cnt #(
      .ROW_MAX  (ROW_MAX),
      .COL_MAX  (COL_MAX),
      .FILT_MAX (FILT_MAX)
   ) u_win_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (abort || (state_q == DONE)),
      .adv     (handshake),
      .row     (win_row),
      .col     (win_col),
      .filt    (win_filt),
      .last    (win_last)
   );

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: randomized ready stalls and
// abort points, checked against a nested-loop window reference.
// Honours CONV_PAD_EN for the expected window range.
module tb_conv_sequencer;

   localparam int IMG = 28;
   localparam int KD  = 3;
   localparam int NF  = 8;
`ifdef CONV_PAD_EN
   localparam int SIDE = IMG;
`else
   localparam int SIDE = IMG - KD + 1;
`endif
   localparam int TOTAL = NF * SIDE * SIDE;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       load_done = 1'b0;
   logic       win_ready = 1'b0;
   logic       en_wr, win_valid, win_last, busy, done;
   logic [4:0] win_row, win_col;
   logic [2:0] win_filt;

   int n_cmp = 0;
   int n_err = 0;

   logic [13:0] exp_q[$];

   conv_sequencer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .load_done (load_done),
      .win_ready (win_ready),
      .en_wr     (en_wr),
      .win_valid (win_valid),
      .win_row   (win_row),
      .win_col   (win_col),
      .win_filt  (win_filt),
      .win_last  (win_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [13:0] pack(input int f, input int r, input int c, input bit l);
      logic [2:0] fb;
      logic [4:0] rb, cb;
      fb = f[2:0];
      rb = r[4:0];
      cb = c[4:0];
      return {fb, rb, cb, l};
   endfunction

   function automatic logic [13:0] observed();
      return {win_filt, win_row, win_col, win_last};
   endfunction

   // Pulse start, hold load_done low until en_wr has been seen for
   // load_cycles cycles (unless already high), and report en_wr duration.
   task automatic start_and_load(input int load_cycles, output int en_cycles);
      int guard;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      en_cycles = 0;
      guard = 0;
      while (en_wr && guard < 5000) begin
         en_cycles++;
         guard++;
         if (en_cycles >= load_cycles) load_done = 1'b1;
         @(negedge clk);
      end
      check("load_timeout", guard < 5000, 1);
      check("conv_entry_valid", win_valid, 1);
      check("conv_entry_busy", busy, 1);
   endtask

   // Drive win_ready with stall_pct percent stalls, checking every cycle
   // against the reference sequence. abort_beat >= 0 aborts after that
   // many handshakes. Returns the number of handshakes seen.
   task automatic run_windows(input int stall_pct, input int abort_beat, output int beats,
                              output logic [13:0] last_hs);
      int          idx = 0;
      int          cyc = 0;
      logic [13:0] cur, prev;
      logic        prev_stall = 1'b0;
      last_hs = '0;
      prev = '0;
      while (idx < TOTAL && cyc < 40000) begin
         cyc++;
         cur = observed();
         check("win_valid", win_valid, 1);
         if (prev_stall) check("stall_hold", cur, prev);
         check("window", cur, exp_q[idx]);
         if (last_hs == pack(2, 0, SIDE - 1, 0) && idx > 0 && !prev_stall)
            check("wrap_row", cur, pack(2, 1, 0, 0));
         if (last_hs == pack(2, SIDE - 1, SIDE - 1, 0) && idx > 0 && !prev_stall)
            check("wrap_filt", cur, pack(3, 0, 0, 0));
         if (abort_beat >= 0 && idx == abort_beat) begin
            abort = 1'b1;
            win_ready = 1'($urandom_range(1));
            @(negedge clk);
            abort = 1'b0;
            win_ready = 1'b0;
            beats = idx;
            return;
         end
         win_ready = ($urandom_range(99) >= stall_pct);
         prev = cur;
         prev_stall = !win_ready;
         if (win_ready) begin
            last_hs = cur;
            idx++;
         end
         @(negedge clk);
      end
      check("run_timeout", cyc < 40000, 1);
      win_ready = 1'b0;
      beats = idx;
   endtask

   // After the final handshake: one done pulse, outputs back to idle values.
   task automatic check_done(input string tag);
      int pulses = 0;
      check({tag, "_done_now"}, done, 1);
      check({tag, "_valid_drop"}, win_valid, 0);
      check({tag, "_coord_zero"}, observed(), 0);
      check({tag, "_busy_drop"}, busy, 0);
      for (int i = 0; i < 4; i++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      check({tag, "_done_pulses"}, pulses, 1);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      int          en_cycles, beats, dcount;
      logic [13:0] last_hs;

      for (int f = 0; f < NF; f++)
         for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++)
               exp_q.push_back(pack(f, r, c, (f == NF - 1) && (r == SIDE - 1) && (c == SIDE - 1)));

      // Reset values.
      #12;
      check("reset_outputs", {en_wr, win_valid, win_row, win_col, win_filt, win_last, busy, done}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", {en_wr, busy, win_valid}, 0);

      // Full run, loader finishes 784 cycles after start, no stalls.
      start_and_load(IMG * IMG, en_cycles);
      check("en_wr_cycles", en_cycles, IMG * IMG);
      run_windows(0, -1, beats, last_hs);
      check("beats_nostall", beats, TOTAL);
      check("last_window", last_hs, pack(NF - 1, SIDE - 1, SIDE - 1, 1));
      check_done("run1");

      // load_done retained: one-cycle LOAD, then a run with ~50% stalls.
      start_and_load(1, en_cycles);
      check("en_wr_retained", en_cycles, 1);
      run_windows(50, -1, beats, last_hs);
      check("beats_stall", beats, TOTAL);
      check("last_window_stall", last_hs, pack(NF - 1, SIDE - 1, SIDE - 1, 1));
      check_done("run2");

      // Abort after 1000 handshakes, then restart from (0,0,0).
      start_and_load(1, en_cycles);
      run_windows(30, 1000, beats, last_hs);
      check("abort_beat", beats, 1000);
      check("abort_valid", win_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_coord", observed(), 0);
      dcount = 0;
      for (int i = 0; i < 3; i++) begin
         if (done) dcount++;
         @(negedge clk);
      end
      check("abort_no_done", dcount, 0);
      start_and_load(1, en_cycles);
      check("restart_load_len", en_cycles, 1);
      check("restart_origin", observed(), pack(0, 0, 0, 0));
      run_windows(25, -1, beats, last_hs);
      check("beats_restart", beats, TOTAL);
      check_done("run3");

      // abort together with start in IDLE stays idle.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_idle", {en_wr, busy}, 0);
      @(negedge clk);
      check("abort_start_idle2", {en_wr, busy}, 0);

      // Asynchronous reset mid-LOAD.
      load_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_load_en_wr", en_wr, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset", {en_wr, win_valid, win_row, win_col, win_filt, win_last, busy, done}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      load_done = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_async", {en_wr, busy, win_valid, done}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Top-level controller for the BNN convolution layer. It arms the pixel/weight loader, waits for the 28×28 image and eight 3×3 binary kernels to be resident, then walks every output position for every filter. It issues one window coordinate per cycle to the XNOR/popcount engine under a valid/ready handshake, and reports completion to the host interface.

## Interface
Parameters:
- `IMG_DIM`, 28: image side length in pixels.
- `K_DIM`, 3: kernel side length.
- `N_FILT`, 8: number of filters.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to run one inference; honoured only in IDLE.
- `abort`  in  1  synchronous cancel; forces IDLE on the next edge from any state.
- `load_done`  in  1  loader status: image and weights fully captured.
- `win_ready`  in  1  engine accepts the current window.
- `en_wr`  out  1  write enable to the loader.
- `win_valid`  out  1  window coordinate valid.
- `win_row`  out  5  window row coordinate.
- `win_col`  out  5  window column coordinate.
- `win_filt`  out  3  filter index.
- `win_last`  out  1  qualifies the final window of the run.
- `busy`  out  1  high in LOAD and CONV.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, LOAD, CONV, DONE. The state register is the only source of the control outputs; all outputs are registered.
- **IDLE**
  - `start`=1 → LOAD. `start` in any other state is ignored.
- **LOAD**
  - `en_wr`=1.
  - `load_done`=1 → CONV, with `en_wr` dropping in the same edge.
  - If `load_done` is already high on entry (weights/image retained from a previous run), LOAD lasts exactly one cycle.
- **CONV**
  - `win_valid`=1. Coordinates advance only on a handshake (`win_valid` && `win_ready`).
  - Iteration order: `win_filt` outermost (0..N_FILT-1), then `win_row`, then `win_col` innermost.
  - `win_col` wraps to 0 and increments `win_row`. `win_row` wraps to 0 and increments `win_filt`.
  - `win_last`=1 exactly when the coordinates are (N_FILT-1, RMAX, CMAX).
  - A handshake with `win_last` → DONE. Coordinates return to 0 and `win_valid` drops in the same edge.
  - While `win_ready`=0, every output holds stable, including `win_last`.
- **DONE**
  - `done`=1 for one cycle → IDLE.
- **abort**
  - Highest priority. From any state, the next state is IDLE, counters clear to 0, and `done` is not pulsed.
  - `abort` and `start` together in IDLE → remain IDLE.
- Coordinate range without padding: RMAX = CMAX = IMG_DIM-K_DIM = 25. Coordinates are the window's top-left corner. A run is 8×26×26 = 5408 beats.
- Counters are sized from the package constants. No counter may exceed its maximum; wrap happens only through the explicit compare.

## Timing
- Reset values: state=IDLE, `en_wr`=0, `win_valid`=0, `win_row`=`win_col`=`win_filt`=0, `win_last`=0, `busy`=0, `done`=0.
- Latency:
  - `start` sampled at edge N → `en_wr`/`busy` high after edge N.
  - `load_done` sampled at edge M → `win_valid` high after edge M.
  - Final handshake at edge K → `done` high for the cycle after K, and IDLE after K+1.
- With `win_ready` held high, CONV issues one window per cycle with no bubbles, including at row and filter wraps.
- Reset asserted mid-run: everything returns to reset values asynchronously. After release, the block idles until a new `start`.

## Configuration
- `CONV_PAD_EN`
  - Defined: zero-padded "same" convolution. Coordinates are the window centre, RMAX = CMAX = IMG_DIM-1 = 27, giving 8×28×28 = 6272 beats. The engine treats out-of-image taps as 0.
  - Undefined: valid convolution as described in Operation (RMAX = CMAX = 25, 5408 beats).

## Structure
- Shared package `bnn_pkg`:
  - constants `IMG_DIM`, `K_DIM`, `N_FILT`
  - derived `OUT_DIM` (depends on `CONV_PAD_EN`)
  - typedef `seq_state_t` enum {IDLE, LOAD, CONV, DONE}
  - coordinate typedefs `coord_t` (5 bits) and `filt_t` (3 bits)
- One sub-module, `conv_win_cnt`: the nested filter/row/col counter. Inputs are `clk`, `reset_n`, `clr`, `adv`; outputs are the coordinates and `last`. The parent FSM drives `clr` (abort or DONE) and `adv` (the handshake).

## Test plan
- Reset, `start` pulse, `load_done` rising 784 cycles later, `win_ready`=1 → `en_wr` high exactly 784 cycles; 5408 windows; first (0,0,0); last (7,25,25) with `win_last`; `done` a single pulse; `busy` low afterwards.
- Random `win_ready` stalls (~50%) → coordinates and `win_last` stable while stalled; the sequence equals the no-stall reference; still 5408 handshakes.
- Wrap check → handshake at (2,0,25) is followed by (2,1,0); handshake at (2,25,25) is followed by (3,0,0).
- `abort` at beat 1000 of CONV → next cycle: IDLE, `win_valid`=0, coordinates 0, no `done`. A new `start` with `load_done` still high → LOAD for one cycle, then restart at (0,0,0).
- `reset_n` low asynchronously mid-LOAD → all outputs at reset values immediately, without a clock edge.
- With `CONV_PAD_EN` defined → 6272 beats; last window (7,27,27).
